// File: rtl/lru_ctrl_pkg.sv
// lru_ctrl_pkg: controller FSM states and LRU array replace-command codes.
package lru_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        TOUCH,
        VREAD,
        VRESP
    } lru_state_e;

    typedef logic [1:0] lru_cmd_t;

    localparam lru_cmd_t LRU_INIT   = 2'b00;
    localparam lru_cmd_t LRU_TOUCH  = 2'b01;
    localparam lru_cmd_t LRU_ROTATE = 2'b10;
    localparam lru_cmd_t LRU_HOLD   = 2'b11;

endpackage

// File: rtl/lru_req_arb.sv
// lru_req_arb: one-hot hit/miss grant, miss first; with LRU_CTRL_STARVE_GUARD_EN
// a waiting hit is forced through after STARVE_LIMIT consecutive miss grants.
module lru_req_arb
`ifdef LRU_CTRL_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef LRU_CTRL_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
`endif
    input  logic qual,
    input  logic hit_valid,
    input  logic miss_valid,
    output logic hit_gnt,
    output logic miss_gnt
);

    logic force_hit;
    logic miss_win;

`ifdef LRU_CTRL_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign force_hit = hit_valid && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            starve_cnt <= '0;
        end else if (hit_gnt) begin
            starve_cnt <= '0;
        end else if (miss_gnt && hit_valid && (starve_cnt != CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_hit = 1'b0;
`endif

    assign miss_win = miss_valid && !force_hit;
    assign miss_gnt = qual && miss_win;
    assign hit_gnt  = qual && hit_valid && !miss_win;

endmodule

// File: rtl/lru_ctrl.sv
// lru_ctrl: sequences init/touch/victim commands to the per-set LRU array.
// Optional LRU_CTRL_STARVE_GUARD_EN bounds how long a hit can wait behind misses.
module lru_ctrl
    import lru_ctrl_pkg::*;
#(
    parameter int ASSOC        = 8,
    parameter int INDEX_SIZE   = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_req,
    output logic                     flush_ack,
    input  logic                     hit_valid,
    output logic                     hit_ready,
    input  logic [INDEX_SIZE-1:0]    hit_index,
    input  logic [$clog2(ASSOC)-1:0] hit_way,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [INDEX_SIZE-1:0]    miss_index,
    output logic                     victim_valid,
    input  logic                     victim_ready,
    output logic [$clog2(ASSOC)-1:0] victim_way,
    output logic [1:0]               lru_replace,
    output logic [INDEX_SIZE-1:0]    lru_index,
    output logic [$clog2(ASSOC)-1:0] lru_assoc,
    input  logic [$clog2(ASSOC)-1:0] lru_way,
    output logic                     init_done
);

    localparam int WW = $clog2(ASSOC);

    if (ASSOC < 2 || (ASSOC & (ASSOC - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("lru_ctrl: unsupported parameter set");
    end

    lru_state_e            state, state_n;
    lru_cmd_t              rep_n;
    logic [INDEX_SIZE-1:0] idx_n;
    logic [WW-1:0]         asc_n, vway_n;
    logic                  vvalid_n, ack_n, done_n;
    logic                  idle, arb_qual;
    logic                  hit_gnt, miss_gnt;

    assign idle       = (state == IDLE) && init_done;
    assign arb_qual   = idle && !flush_req;
    assign hit_ready  = hit_gnt;
    assign miss_ready = miss_gnt;

`ifdef LRU_CTRL_STARVE_GUARD_EN
    lru_req_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (idle && flush_req),
        .qual      (arb_qual),
        .hit_valid (hit_valid),
        .miss_valid(miss_valid),
        .hit_gnt   (hit_gnt),
        .miss_gnt  (miss_gnt)
    );
`else
    lru_req_arb u_arb (
        .qual      (arb_qual),
        .hit_valid (hit_valid),
        .miss_valid(miss_valid),
        .hit_gnt   (hit_gnt),
        .miss_gnt  (miss_gnt)
    );
`endif

    always_comb begin
        state_n  = state;
        rep_n    = LRU_HOLD;
        idx_n    = lru_index;
        asc_n    = lru_assoc;
        vway_n   = victim_way;
        vvalid_n = 1'b0;
        ack_n    = 1'b0;
        done_n   = init_done;
        unique case (state)
            // After reset the 00 command has not gone out yet; issue it first.
            INIT: begin
                if (lru_replace == LRU_INIT) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    rep_n  = LRU_INIT;
                    done_n = 1'b0;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_n = INIT;
                    rep_n   = LRU_INIT;
                    ack_n   = 1'b1;
                    done_n  = 1'b0;
                end else if (miss_gnt) begin
                    state_n = VREAD;
                    idx_n   = miss_index;
                end else if (hit_gnt) begin
                    state_n = TOUCH;
                    rep_n   = LRU_TOUCH;
                    idx_n   = hit_index;
                    asc_n   = hit_way;
                end
            end
            TOUCH: begin
                state_n = IDLE;
            end
            VREAD: begin
                state_n  = VRESP;
                rep_n    = LRU_TOUCH;
                asc_n    = lru_way;
                vway_n   = lru_way;
                vvalid_n = 1'b1;
            end
            VRESP: begin
                if (victim_ready) begin
                    state_n = IDLE;
                end else begin
                    vvalid_n = 1'b1;
                end
            end
            default: begin
                state_n = INIT;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= INIT;
            lru_replace  <= LRU_HOLD;
            lru_index    <= '0;
            lru_assoc    <= '0;
            victim_way   <= '0;
            victim_valid <= 1'b0;
            flush_ack    <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            state        <= state_n;
            lru_replace  <= rep_n;
            lru_index    <= idx_n;
            lru_assoc    <= asc_n;
            victim_way   <= vway_n;
            victim_valid <= vvalid_n;
            flush_ack    <= ack_n;
            init_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_lru_ctrl.sv
// tb_lru_ctrl: directed and randomized hit/miss traffic checked against an
// age-stamp LRU model; also drives an LRU array model from the DUT commands.
`timescale 1ns/1ps
module tb_lru_ctrl;

    localparam int ASSOC = 8;
    localparam int IW    = 7;
    localparam int WW    = 3;
    localparam int NSET  = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_ack;
    logic          hit_valid = 1'b0;
    logic          hit_ready;
    logic [IW-1:0] hit_index = '0;
    logic [WW-1:0] hit_way = '0;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [IW-1:0] miss_index = '0;
    logic          victim_valid;
    logic          victim_ready = 1'b0;
    logic [WW-1:0] victim_way;
    logic [1:0]    lru_replace;
    logic [IW-1:0] lru_index;
    logic [WW-1:0] lru_assoc;
    logic [WW-1:0] lru_way = '0;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    // stamp[0]: array seen by the DUT; stamp[1]: expected state from transactions
    int stamp [2][NSET][ASSOC];
    int tnow = 0;
    int touch_cnt = 0;
    int init_cnt = 0;
    int rot_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    lru_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req   (flush_req),
        .flush_ack   (flush_ack),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_index   (hit_index),
        .hit_way     (hit_way),
        .miss_valid  (miss_valid),
        .miss_ready  (miss_ready),
        .miss_index  (miss_index),
        .victim_valid(victim_valid),
        .victim_ready(victim_ready),
        .victim_way  (victim_way),
        .lru_replace (lru_replace),
        .lru_index   (lru_index),
        .lru_assoc   (lru_assoc),
        .lru_way     (lru_way),
        .init_done   (init_done)
    );

    function automatic int lru_of(input int m, input int s);
        int best = 0;
        for (int w = 1; w < ASSOC; w++)
            if (stamp[m][s][w] < stamp[m][s][best]) best = w;
        return best;
    endfunction

    task automatic touch(input int m, input int s, input int w);
        tnow++;
        stamp[m][s][w] = tnow;
    endtask

    // Fresh state: highest way is least recently used.
    task automatic init_model(input int m);
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < ASSOC; w++)
                stamp[m][s][w] = -1 - w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            case (lru_replace)
                2'b00: begin init_cnt++; init_model(0); end
                2'b01: begin touch_cnt++; touch(0, int'(lru_index), int'(lru_assoc)); end
                2'b10: rot_cnt++;
                default: ;
            endcase
            if (hit_ready && miss_ready) both_cnt++;
        end
    end

    always @(negedge clk) lru_way = WW'(lru_of(0, int'(lru_index)));

    task automatic hit_req(input int s, input int w);
        int n = 0;
        hit_valid = 1'b1;
        hit_index = IW'(s);
        hit_way   = WW'(w);
        #1;
        while (!hit_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("hit_grant", 32'(n < 20), 1);
        @(negedge clk);
        check("touch_cmd", lru_replace, 1);
        check("touch_idx", lru_index, s);
        check("touch_way", lru_assoc, w);
        check("hit_ready_busy", hit_ready, 0);
        hit_valid = 1'b0;
        touch(1, s, w);
    endtask

    task automatic miss_req(input int s, input int hold, output int v);
        int n = 0;
        int exp;
        int t0;
        miss_valid = 1'b1;
        miss_index = IW'(s);
        #1;
        while (!miss_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("miss_grant", 32'(n < 20), 1);
        t0  = touch_cnt;
        exp = lru_of(1, s);
        @(negedge clk);
        check("vread_cmd", lru_replace, 3);
        check("vread_idx", lru_index, s);
        check("vread_valid", victim_valid, 0);
        miss_valid = 1'b0;
        @(negedge clk);
        check("vresp_valid", victim_valid, 1);
        check("victim_way", victim_way, exp);
        check("vresp_touch", lru_replace, 1);
        check("vresp_assoc", lru_assoc, exp);
        check("vresp_idx", lru_index, s);
        victim_ready = (hold == 0);
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            check("vresp_hold_valid", victim_valid, 1);
            check("vresp_hold_way", victim_way, exp);
            check("vresp_hold_cmd", lru_replace, 3);
            victim_ready = (k == hold);
        end
        @(negedge clk);
        victim_ready = 1'b0;
        check("vresp_done", victim_valid, 0);
        check("miss_touch_count", touch_cnt - t0, 1);
        touch(1, s, exp);
        v = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v, s, w, n, g, pend, exp, i0;
        bit exp_hit;

        // Reset state with requests already pending
        hit_valid  = 1'b1;
        miss_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_replace", lru_replace, 3);
        check("rst_init_done", init_done, 0);
        check("rst_hit_ready", hit_ready, 0);
        check("rst_miss_ready", miss_ready, 0);
        check("rst_victim_valid", victim_valid, 0);
        check("rst_flush_ack", flush_ack, 0);
        check("rst_index", lru_index, 0);
        check("rst_assoc", lru_assoc, 0);
        check("rst_victim_way", victim_way, 0);
        hit_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_cmd", lru_replace, 0);
        check("init_done_low", init_done, 0);
        check("init_miss_ready", miss_ready, 0);
        @(negedge clk);
        check("init_done_high", init_done, 1);
        check("idle_cmd", lru_replace, 3);
        check("idle_miss_ready", miss_ready, 1);
        check("init_count", init_cnt, 1);
        init_model(1);

        miss_req(5, 0, v);
        check("fresh_victim_5", v, 7);
        hit_req(3, 2);
        miss_req(9, 4, v);
        check("fresh_victim_9", v, 7);

        // Randomized traffic over a few sets so touches and misses collide
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 7);
            w = $urandom_range(0, ASSOC - 1);
            if ($urandom_range(0, 1) == 1) hit_req(s, w);
            else miss_req(s, $urandom_range(0, 3), v);
        end

        // Both requesters held continuously
        hit_valid    = 1'b1;
        hit_index    = IW'(21);
        hit_way      = WW'(1);
        miss_valid   = 1'b1;
        miss_index   = IW'(20);
        victim_ready = 1'b1;
        g = 0; n = 0; pend = -1;
        while (g < 15 && n < 200) begin
            #1;
            if (victim_valid) check("starve_victim", victim_way, pend);
`ifdef LRU_CTRL_STARVE_GUARD_EN
            exp_hit = (g % 5 == 4);
`else
            exp_hit = 1'b0;
`endif
            if (miss_ready) begin
                check("starve_order", 0, 32'(exp_hit));
                pend = lru_of(1, 20);
                touch(1, 20, pend);
                g++;
            end else if (hit_ready) begin
                check("starve_order", 1, 32'(exp_hit));
                touch(1, 21, 1);
                g++;
            end
            @(negedge clk);
            n++;
        end
        check("starve_grants", g, 15);
        hit_valid  = 1'b0;
        miss_valid = 1'b0;
        repeat (4) @(negedge clk);
        victim_ready = 1'b0;

        // Flush raised during VRESP waits for the response to finish
        miss_valid = 1'b1;
        miss_index = IW'(40);
        n = 0;
        #1;
        while (!miss_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("fl_miss_grant", 32'(n < 20), 1);
        exp = lru_of(1, 40);
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        i0 = init_cnt;
        check("fl_victim_way", victim_way, exp);
        check("fl_vresp_touch", lru_replace, 1);
        repeat (2) begin
            @(negedge clk);
            check("fl_deferred_ack", flush_ack, 0);
            check("fl_hold_valid", victim_valid, 1);
        end
        victim_ready = 1'b1;
        @(negedge clk);
        victim_ready = 1'b0;
        touch(1, 40, exp);
        hit_valid  = 1'b1;
        hit_index  = IW'(1);
        hit_way    = WW'(0);
        miss_valid = 1'b1;
        #1;
        check("fl_cycle_hit_ready", hit_ready, 0);
        check("fl_cycle_miss_ready", miss_ready, 0);
        check("fl_cycle_victim", victim_valid, 0);
        check("fl_cycle_ack", flush_ack, 0);
        @(negedge clk);
        check("fl_ack_pulse", flush_ack, 1);
        check("fl_init_cmd", lru_replace, 0);
        check("fl_init_done_low", init_done, 0);
        check("fl_init_hit_ready", hit_ready, 0);
        flush_req = 1'b0;
        @(negedge clk);
        check("fl_ack_done", flush_ack, 0);
        check("fl_init_done_high", init_done, 1);
        check("fl_after_cmd", lru_replace, 3);
        check("fl_init_count", init_cnt - i0, 1);
        check("fl_after_miss_ready", miss_ready, 1);
        check("fl_after_hit_ready", hit_ready, 0);
        hit_valid = 1'b0;
        init_model(1);
        miss_req(40, 0, v);
        check("post_flush_victim", v, 7);

        // Reset in the middle of a victim read
        miss_valid = 1'b1;
        miss_index = IW'(50);
        n = 0;
        #1;
        while (!miss_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("rs_miss_grant", 32'(n < 20), 1);
        @(negedge clk);
        miss_valid = 1'b0;
        check("rs_vread_cmd", lru_replace, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_victim_valid", victim_valid, 0);
        check("rs_init_done", init_done, 0);
        check("rs_replace", lru_replace, 3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_init_cmd", lru_replace, 0);
        check("rs_no_victim", victim_valid, 0);
        @(negedge clk);
        check("rs_init_done_high", init_done, 1);
        check("rs_no_victim_idle", victim_valid, 0);
        init_model(1);
        miss_req(50, 0, v);
        check("post_reset_victim", v, 7);

        check("no_rotate", rot_cnt, 0);
        check("readies_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
